// File: rtl/line_pkg.sv
// Shared encodings, widths and sensor weighting for the line-follower steering path.
package line_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOST  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int ERR_W = 6;
    localparam int RAW_W = 12;

    localparam logic [7:0] SERVO_CENTER  = 8'd128;
    localparam logic [7:0] SERVO_LEFT    = 8'd0;
    localparam logic [7:0] SERVO_RIGHT   = 8'd255;
    localparam logic [7:0] SENSORS_NONE  = 8'h00;
    localparam logic [7:0] SENSORS_CROSS = 8'hFF;

    // Index 0 is the leftmost sensor.
    localparam logic signed [ERR_W-1:0] SENSOR_WEIGHT [8] = '{
        -6'sd7, -6'sd5, -6'sd3, -6'sd1, 6'sd1, 6'sd3, 6'sd5, 6'sd7
    };

    function automatic logic signed [ERR_W-1:0] line_err(input logic [7:0] s);
        logic signed [ERR_W-1:0] acc;
        acc = '0;
        if (s != SENSORS_CROSS) begin
            for (int i = 0; i < 8; i++) begin
                if (s[i]) acc = acc + SENSOR_WEIGHT[i];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Control-frame divider: counts 0..UPDATE_DIV-1 and flags the cycle that wraps back to 0.
module frame_tick #(
    parameter int UPDATE_DIV = 2000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/line_to_servo.sv
// Line-follower steering: sensor error -> PD steering command, one update per control frame.
// Define LINE_DERIV_EN to include the derivative term; otherwise steering is proportional only.
//   state | meaning
//   IDLE  | run low, servo centred
//   TRACK | line visible, PD steering each frame
//   LOST  | line gone, full lock toward last known side
//   HALT  | line lost too long, centred until run drops
module line_to_servo
    import line_pkg::*;
#(
    parameter int UPDATE_DIV  = 2000000,
    parameter int KP          = 4,
    parameter int KD          = 2,
    parameter int LOST_FRAMES = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sensors,
    input  logic       run,
    output logic [7:0] servo,
    output logic       servo_valid,
    output logic [1:0] state,
    output logic       halted
);
    localparam logic signed [RAW_W-1:0] KP_S       = RAW_W'(KP);
    localparam logic signed [RAW_W-1:0] KD_S       = RAW_W'(KD);
    localparam logic signed [RAW_W-1:0] RAW_CENTER = RAW_W'(SERVO_CENTER);
    localparam logic [7:0]              LOST_LIMIT = 8'(LOST_FRAMES);

    state_e                  state_q, state_d;
    logic                    tick;
    logic [7:0]              sync1_q, sync2_q;
    logic [7:0]              lost_cnt_q, lost_cnt_d;
    logic signed [ERR_W-1:0] err_now;
    logic                    prev_neg;
    logic                    launch, job_fixed, load_prev, clear_prev;
    logic [7:0]              job_val;
    logic                    s1_valid_q, s1_fixed_q;
    logic [7:0]              s1_val_q;
    logic signed [ERR_W-1:0] s1_err_q;
    logic signed [RAW_W-1:0] err_x, diff, raw_d, raw_q;
    logic                    s2_valid_q;
    logic [7:0]              servo_q, servo_d;
    logic                    servo_valid_q;

    frame_tick #(.UPDATE_DIV(UPDATE_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign err_now = line_err(sync2_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        lost_cnt_d = lost_cnt_q;
        launch     = 1'b0;
        job_fixed  = 1'b0;
        job_val    = SERVO_CENTER;
        load_prev  = 1'b0;
        clear_prev = 1'b0;
        if (!run) begin
            state_d    = ST_IDLE;
            clear_prev = 1'b1;
        end else if (tick) begin
            unique case (state_q)
                ST_IDLE: state_d = ST_TRACK;
                ST_TRACK: begin
                    launch = 1'b1;
                    if (sync2_q == SENSORS_NONE) begin
                        job_fixed  = 1'b1;
                        lost_cnt_d = 8'd1;
                        if (LOST_LIMIT <= 8'd1) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_LOST;
                            job_val = prev_neg ? SERVO_LEFT : SERVO_RIGHT;
                        end
                    end else begin
                        load_prev = 1'b1;
                    end
                end
                ST_LOST: begin
                    launch = 1'b1;
                    if (sync2_q != SENSORS_NONE) begin
                        state_d   = ST_TRACK;
                        load_prev = 1'b1;
                    end else begin
                        job_fixed  = 1'b1;
                        lost_cnt_d = lost_cnt_q + 8'd1;
                        if (lost_cnt_d == LOST_LIMIT) state_d = ST_HALT;
                        else job_val = prev_neg ? SERVO_LEFT : SERVO_RIGHT;
                    end
                end
                ST_HALT: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef LINE_DERIV_EN
    logic signed [ERR_W-1:0] err_prev_q, s1_errp_q;

    assign prev_neg = err_prev_q[ERR_W-1];

    // Re-acquiring from LOST uses the new error as its own history: no derivative kick.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_prev_q <= '0;
            s1_errp_q  <= '0;
        end else begin
            s1_errp_q <= (state_q == ST_LOST) ? err_now : err_prev_q;
            if (clear_prev)     err_prev_q <= '0;
            else if (load_prev) err_prev_q <= err_now;
        end
    end

    assign diff = err_x - $signed({{(RAW_W-ERR_W){s1_errp_q[ERR_W-1]}}, s1_errp_q});
`else
    logic err_neg_q;

    assign prev_neg = err_neg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_neg_q <= 1'b0;
        end else begin
            if (clear_prev)     err_neg_q <= 1'b0;
            else if (load_prev) err_neg_q <= err_now[ERR_W-1];
        end
    end

    assign diff = '0;
`endif

    assign err_x = $signed({{(RAW_W-ERR_W){s1_err_q[ERR_W-1]}}, s1_err_q});

    always_comb begin
        if (s1_fixed_q) raw_d = $signed({4'b0000, s1_val_q});
        else            raw_d = RAW_CENTER + KP_S * err_x + KD_S * diff;
    end

    always_comb begin
        if (raw_q[RAW_W-1])          servo_d = 8'd0;
        else if (|raw_q[RAW_W-2:8])  servo_d = 8'd255;
        else                         servo_d = raw_q[7:0];
    end

    // Dropping run kills every in-flight stage so a stale frame never reaches the servo.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            lost_cnt_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_fixed_q    <= 1'b0;
            s1_val_q      <= '0;
            s1_err_q      <= '0;
            s2_valid_q    <= 1'b0;
            raw_q         <= '0;
            servo_q       <= SERVO_CENTER;
            servo_valid_q <= 1'b0;
        end else begin
            sync1_q    <= sensors;
            sync2_q    <= sync1_q;
            lost_cnt_q <= lost_cnt_d;
            s1_fixed_q <= job_fixed;
            s1_val_q   <= job_val;
            s1_err_q   <= err_now;
            raw_q      <= raw_d;
            if (!run) begin
                s1_valid_q    <= 1'b0;
                s2_valid_q    <= 1'b0;
                servo_valid_q <= 1'b0;
                servo_q       <= SERVO_CENTER;
            end else begin
                s1_valid_q    <= launch;
                s2_valid_q    <= s1_valid_q;
                servo_valid_q <= s2_valid_q;
                if (s2_valid_q) servo_q <= servo_d;
            end
        end
    end

    assign servo       = servo_q;
    assign servo_valid = servo_valid_q;
    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_line_to_servo.sv
// Directed bench for line_to_servo: frame-aligned vectors with hand-computed steering values.
module tb_line_to_servo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sensors = 8'h00;
    logic       run = 1'b0;
    logic [7:0] servo;
    logic       servo_valid;
    logic [1:0] state;
    logic       halted;

    int unsigned cyc;
    int          n_vec = 0;
    int          n_bad = 0;

`ifdef LINE_DERIV_EN
    localparam logic [7:0] E_KICK = 8'd170, E_NEG = 8'd18, E_CLAMP_HI = 8'd255,
                           E_CLAMP_LO = 8'd0, E_CROSS = 8'd160, E_POS = 8'd170;
`else
    localparam logic [7:0] E_KICK = 8'd156, E_NEG = 8'd64, E_CLAMP_HI = 8'd192,
                           E_CLAMP_LO = 8'd64, E_CROSS = 8'd128, E_POS = 8'd156;
`endif

    line_to_servo #(
        .UPDATE_DIV  (100),
        .KP          (4),
        .KD          (2),
        .LOST_FRAMES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensors     (sensors),
        .run         (run),
        .servo       (servo),
        .servo_valid (servo_valid),
        .state       (state),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; DUT frame counter equals cyc % 100, tick at 99.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to 3 cycles after the next tick and check the frame's result there.
    task automatic frame(input string tag, input logic exp_v, input logic [7:0] exp_servo,
                         input logic [1:0] exp_state);
        int   b;
        logic stray;
        b     = 0;
        stray = 1'b0;
        do begin
            step();
            b++;
            if (servo_valid && (cyc % 100 != 2)) stray = 1'b1;
        end while ((cyc % 100 != 2) && (b < 250));
        if (b >= 250) chk({tag, "_timeout"}, 1, 0);
        chk({tag, "_stray"},  stray,       0);
        chk({tag, "_valid"},  servo_valid, exp_v);
        chk({tag, "_servo"},  servo,       exp_servo);
        chk({tag, "_state"},  state,       exp_state);
        chk({tag, "_halted"}, halted,      exp_state == 2'd3);
        if (exp_v) begin
            step();
            chk({tag, "_pulse"}, servo_valid, 0);
        end
    endtask

    initial begin
        int   b;
        logic stray;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_servo",  servo,       128);
        chk("rst_valid",  servo_valid, 0);
        chk("rst_state",  state,       0);
        chk("rst_halted", halted,      0);
        rst = 1'b0;
        repeat (3) step();

        run = 1'b1;
        sensors = 8'h18;
        frame("enter_track", 0, 8'd128, 2'd1);
        frame("center",      1, 8'd128, 2'd1);

        sensors = 8'h80;
        frame("kick",  1, E_KICK, 2'd1);
        frame("right", 1, 8'd156, 2'd1);

        sensors = 8'h0F;
        frame("swing_left", 1, E_NEG, 2'd1);
        frame("left",       1, 8'd64, 2'd1);

        sensors = 8'hF0;
        frame("clamp_hi",  1, E_CLAMP_HI, 2'd1);
        frame("far_right", 1, 8'd192,     2'd1);

        sensors = 8'h0F;
        frame("clamp_lo", 1, E_CLAMP_LO, 2'd1);

        sensors = 8'hFF;
        frame("crossing", 1, E_CROSS, 2'd1);

        sensors = 8'h80;
        frame("last_right", 1, E_POS, 2'd1);

        sensors = 8'h00;
        frame("lost1", 1, 8'd255, 2'd2);
        frame("lost2", 1, 8'd255, 2'd2);
        frame("halt",  1, 8'd128, 2'd3);

        sensors = 8'h18;
        frame("halt_hold", 0, 8'd128, 2'd3);

        run = 1'b0;
        step();
        chk("stop_state",  state,  0);
        chk("stop_halted", halted, 0);
        chk("stop_servo",  servo,  128);

        run = 1'b1;
        sensors = 8'h80;
        frame("restart",     0, 8'd128, 2'd1);
        frame("restart_trk", 1, E_POS,  2'd1);

        b = 0;
        do begin
            step();
            b++;
        end while ((cyc % 100 != 0) && (b < 250));
        if (b >= 250) chk("drop_align_timeout", 1, 0);
        run = 1'b0;
        step();
        chk("drop_state", state, 0);
        chk("drop_servo", servo, 128);
        stray = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (servo_valid) stray = 1'b1;
        end
        chk("drop_no_valid", stray, 0);
        chk("drop_hold",     servo, 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/line_to_servo.md
LINE_TO_SERVO -- requirements
Module: line_to_servo

Interface
REQ-001 Parameter UPDATE_DIV, default 2000000: clk cycles per control frame (20 ms at 100 MHz, matching the downstream PWM period).
REQ-002 Parameter KP, default 4: proportional gain, unsigned, range 0..7.
REQ-003 Parameter KD, default 2: derivative gain, unsigned, range 0..7.
REQ-004 Parameter LOST_FRAMES, default 25: consecutive line-absent frames before halting, range 1..255.
REQ-005 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port sensors, input, 8: asynchronous IR line sensors; 1 = line seen; bit0 = leftmost.
REQ-008 Port run, input, 1: level enable for steering.
REQ-009 Port servo, output, 8: steering command to the PWM stage; 128 = straight, 0 = full left, 255 = full right.
REQ-010 Port servo_valid, output, 1: one-cycle pulse when servo updates.
REQ-011 Port state, output, 2: current FSM state (IDLE=0, TRACK=1, LOST=2, HALT=3).
REQ-012 Port halted, output, 1: high while in HALT.

Function
REQ-013 sensors SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A frame counter SHALL count 0..UPDATE_DIV-1 and wrap; frame tick = cycle on which it wraps to 0.
REQ-015 On a tick, the synchronized sensors SHALL be sampled; err = signed sum of per-bit weights -7,-5,-3,-1,+1,+3,+5,+7 (bit0..bit7) over set bits; range -16..+16, 6-bit signed.
REQ-016 raw = 128 + KP*err + KD*(err - err_prev), computed in 12-bit signed; servo = raw clamped to 0..255.
REQ-017 Pipeline: sample/err at tick+1, raw at tick+2, servo and servo_valid registered at tick+3; latency exactly 3 cycles; servo holds between updates.
REQ-018 err_prev SHALL update to err on every TRACK-state tick only.
REQ-019 sensors = 0xFF (crossing marker) SHALL be treated as err = 0 in TRACK.
REQ-020 IDLE: servo = 128; on a tick with run=1 -> TRACK.
REQ-021 TRACK: tick with sensors = 0x00 -> LOST, lost_cnt = 1; otherwise steer per REQ-016.
REQ-022 LOST: servo = 0 if err_prev < 0, else 255, pulsed per tick with REQ-017 latency; tick with any sensor set -> TRACK with err_prev loaded with current err (no derivative kick); tick with 0x00 increments lost_cnt; lost_cnt reaching LOST_FRAMES -> HALT.
REQ-023 HALT: servo = 128, halted = 1; sensors ignored; exit only via run=0.
REQ-024 run=0 in any state SHALL force IDLE, servo = 128, on the next cycle regardless of tick; in-flight pipeline results are discarded and produce no servo_valid.

Reset
REQ-025 On rst: servo = 128, servo_valid = 0, state = IDLE, halted = 0; frame counter, lost_cnt, err_prev, pipeline registers and synchronizer = 0.
REQ-026 rst asserted mid-frame or mid-pipeline SHALL take effect on the next edge and suppress pending servo_valid.

Configuration
REQ-027 Macro LINE_DERIV_EN defined: derivative term per REQ-016 present.
REQ-028 Macro LINE_DERIV_EN undefined: raw = 128 + KP*err; KD ignored; err_prev kept only as a sign flag for LOST steering; latency unchanged.

Structure
REQ-029 Shared package line_pkg SHALL hold the FSM state encoding, the 8 sensor weights, SERVO_CENTER = 128, and the err/raw widths (6, 12).
REQ-030 Frame divider SHALL be sub-module frame_tick (parameter UPDATE_DIV, outputs tick), reused by the PWM stage.

Verification (UPDATE_DIV = 100, KP = 4, KD = 2, LOST_FRAMES = 3, LINE_DERIV_EN defined unless stated)
REQ-031 rst pulse -> servo = 128, servo_valid = 0, state = 0, halted = 0.
REQ-032 run=1, sensors = 0x18 -> servo = 128, servo_valid one-cycle pulse 3 cycles after each tick, state = 1.
REQ-033 From 0x18, sensors = 0x80 -> 170 on first frame, 156 on next; macro undefined -> 156 both frames.
REQ-034 sensors 0x0F (err -16) steady then 0xF0 -> raw 256 clamped to 255; next frame 192.
REQ-035 Last err +7, then 0x00 -> servo 255, state 2; third empty tick -> state 3, servo 128, halted = 1; sensors 0x18 -> stays HALT; run=0 -> IDLE next cycle.
REQ-036 run dropped 1 cycle after a TRACK tick -> IDLE and servo = 128 next cycle; no servo_valid from that frame.
